// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: delivered instructions and discarded responses.
// Both counters are free-running and wrap at 2^32.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc,
  input  logic        drop_inc,
  output logic [31:0] fetch_count,
  output logic [31:0] drop_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      drop_count  <= '0;
    end else begin
      if (fetch_inc) fetch_count <= fetch_count + 32'd1;
      if (drop_inc)  drop_count  <= drop_count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests, IF/ID register.
// Defining FETCH_PERF_EN adds the FetchCount/DropCount performance counter ports.
//
// state | meaning
// IDLE  | just out of reset, issue starts next cycle
// ISSUE | request for PCF presented to imem
// WAIT  | request accepted, waiting for the response
// HOLD  | response captured while IF/ID is stalled
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] PCNextF,
  input  logic             RedirectE,
  input  logic             StallD,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] PCPlus4F,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      FetchCount,
  output logic [31:0]      DropCount
`endif
);

  localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_INSTR);

  fetch_state_t     state, state_n;
  logic [WIDTH-1:0] pc_n;
  logic             drop, drop_n;
  logic [WIDTH-1:0] hold_q, hold_n;
  logic             deliver;
  logic [WIDTH-1:0] deliver_instr;

  assign PCPlus4F       = PCF + WIDTH'(4);
  assign imem_req_valid = (state == ISSUE);
  assign imem_req_addr  = PCF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      PCF    <= RESET_PC;
      drop   <= 1'b0;
      hold_q <= '0;
    end else begin
      state  <= state_n;
      PCF    <= pc_n;
      drop   <= drop_n;
      hold_q <= hold_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = PCF;
    drop_n        = drop;
    hold_n        = hold_q;
    deliver       = 1'b0;
    deliver_instr = hold_q;

    if (RedirectE) begin
      // A redirect wins over stalls; whatever is in flight becomes stale.
      pc_n = PCNextF;
      case (state)
        IDLE:  state_n = ISSUE;
        ISSUE: begin
          if (imem_req_ready) begin
            drop_n  = 1'b1;
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            drop_n  = 1'b0;
            state_n = ISSUE;
          end else begin
            drop_n  = 1'b1;
          end
        end
        HOLD: begin
          hold_n  = '0;
          state_n = ISSUE;
        end
        default: state_n = IDLE;
      endcase
    end else begin
      case (state)
        IDLE:  state_n = ISSUE;
        ISSUE: begin
          if (imem_req_ready) state_n = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = ISSUE;
            end else if (!StallD) begin
              deliver       = 1'b1;
              deliver_instr = imem_rsp_data;
              pc_n          = PCNextF;
              state_n       = ISSUE;
            end else begin
              hold_n  = imem_rsp_data;
              state_n = HOLD;
            end
          end
        end
        HOLD: begin
          if (!StallD) begin
            deliver       = 1'b1;
            deliver_instr = hold_q;
            pc_n          = PCNextF;
            state_n       = ISSUE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // IF/ID: load on delivery, bubble on redirect or unstalled empty cycle, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (deliver) begin
      InstrD   <= deliver_instr;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end else if (RedirectE || !StallD) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic drop_inc;

  assign drop_inc = (state == HOLD && RedirectE) ||
                    (state == WAIT && imem_rsp_valid && (RedirectE || drop));

  fetch_perf_ctr u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_inc   (deliver),
    .drop_inc    (drop_inc),
    .fetch_count (FetchCount),
    .drop_count  (DropCount)
  );
`endif

endmodule
